// File: rtl/clken_pkg.sv
// Shared constants and helper functions for the clock-enable synthesiser.
// Build option: CLKEN_SYNTH_CEN_EN enables the mid-period (ce_n) enables.
package clken_pkg;

    localparam int ACC_W_DEF       = 24;
    localparam int LOCK_CYCLES_DEF = 1024;

    // Increment that yields f_ce from f_ref with an acc_w-bit accumulator.
    function automatic logic [63:0] inc_for_hz(input logic [63:0] f_ce,
                                               input logic [63:0] f_ref,
                                               input int unsigned acc_w);
        logic [63:0] res;
        if (f_ref == 64'd0) begin
            res = 64'd0;
        end else begin
            res = (f_ce << acc_w) / f_ref;
        end
        return res;
    endfunction

    // Limit an increment to half the accumulator range (f/2, 50% duty).
    function automatic logic [63:0] clamp_inc(input logic [63:0] inc,
                                              input int unsigned acc_w);
        logic [63:0] lim;
        lim = 64'd1 << (acc_w - 32'd1);
        if (inc > lim) begin
            return lim;
        end else begin
            return inc;
        end
    endfunction

endpackage

// File: rtl/clken_nco_ch.sv
// One NCO channel: phase accumulator, active and pending increment,
// wrap enable (ce) and optional mid-period enable (ce_n).
// Build option: CLKEN_SYNTH_CEN_EN builds the ce_n compare logic.
module clken_nco_ch
    import clken_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_upd,
    input  logic [ACC_W-1:0] i_inc,
    output logic             o_busy,
    output logic             o_ce,
    output logic             o_ce_n
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc_act;
    logic [ACC_W-1:0] r_pend;
    logic             r_busy;
    logic             r_ce;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_apply;
    logic [ACC_W-1:0] w_inc_clamped;

    // Next accumulator value, wrap carry and the period-boundary apply condition.
    always_comb begin
        w_sum         = {1'b0, r_acc} + {1'b0, r_inc_act};
        w_carry       = w_sum[ACC_W];
        w_apply       = r_busy & (~i_run | w_carry | (r_inc_act == {ACC_W{1'b0}}));
        w_inc_clamped = ACC_W'(clamp_inc(64'(i_inc), $unsigned(ACC_W)));
    end

    // Accumulator and wrap enable; held at zero while the lock is not qualified.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= {ACC_W{1'b0}};
            r_ce  <= 1'b0;
        end else if (i_run) begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_carry;
        end else begin
            r_acc <= {ACC_W{1'b0}};
            r_ce  <= 1'b0;
        end
    end

    // Pending/active increment handshake; a write on the apply edge stays pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inc_act <= {ACC_W{1'b0}};
            r_pend    <= {ACC_W{1'b0}};
            r_busy    <= 1'b0;
        end else begin
            if (w_apply) begin
                r_inc_act <= r_pend;
            end
            if (i_upd) begin
                r_pend <= w_inc_clamped;
                r_busy <= 1'b1;
            end else if (w_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

`ifdef CLKEN_SYNTH_CEN_EN
    logic r_ce_n;

    // Mid-period enable on the accumulator MSB rising.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ce_n <= 1'b0;
        end else if (i_run) begin
            r_ce_n <= ~r_acc[ACC_W-1] & w_sum[ACC_W-1];
        end else begin
            r_ce_n <= 1'b0;
        end
    end

    assign o_ce_n = r_ce_n;
`else
    assign o_ce_n = 1'b0;
`endif

    assign o_busy = r_busy;
    assign o_ce   = r_ce;

endmodule

// File: rtl/clken_synth.sv
// Multi-channel fractional clock-enable synthesiser with qualified PLL lock.
// Build option: CLKEN_SYNTH_CEN_EN enables the ce_n outputs (tied low otherwise).
module clken_synth
    import clken_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic [NUM_CH-1:0]       cfg_upd,
    input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
    output logic [NUM_CH-1:0]       cfg_busy,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       ce_n,
    output logic                    locked
);

    localparam int               CNT_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_locked;
    logic             w_run;

    // Synchronise raw lock and count consecutive locked cycles (saturating).
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_locked <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
            if (r_sync2) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_locked <= (r_cnt == CNT_MAX);
            end else begin
                r_cnt    <= {CNT_W{1'b0}};
                r_locked <= 1'b0;
            end
        end
    end

    // Channels advance only while qualified; a synced low stops them on the
    // same edge that drops locked, so no enable escapes after lock loss.
    always_comb begin
        w_run = r_locked & r_sync2;
    end

    genvar g;
    for (g = 0; g < NUM_CH; g = g + 1) begin : g_ch
        clken_nco_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .i_clk  (refclk),
            .i_rst  (rst),
            .i_run  (w_run),
            .i_upd  (cfg_upd[g]),
            .i_inc  (cfg_inc[g*ACC_W +: ACC_W]),
            .o_busy (cfg_busy[g]),
            .o_ce   (ce[g]),
            .o_ce_n (ce_n[g])
        );
    end

    assign locked = r_locked;

endmodule

// File: tb/tb_clken_synth.sv
// Randomised self-checking bench for clken_synth against a cycle-level
// phase/rate reference model.
module tb_clken_synth;
    import clken_pkg::*;

    localparam int     NUM_CH      = 3;
    localparam int     ACC_W       = 24;
    localparam int     LOCK_CYCLES = 16;
    localparam longint MOD         = longint'(1) << ACC_W;
    localparam longint HALF        = MOD / 2;

    logic                    refclk = 1'b0;
    logic                    rst;
    logic                    pll_locked;
    logic [NUM_CH-1:0]       cfg_upd;
    logic [NUM_CH*ACC_W-1:0] cfg_inc;
    logic [NUM_CH-1:0]       cfg_busy;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       ce_n;
    logic                    locked;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_phase [NUM_CH];
    longint m_rate  [NUM_CH];
    longint m_pend  [NUM_CH];
    bit     m_busy  [NUM_CH];
    bit     m_ce    [NUM_CH];
    bit     m_cen   [NUM_CH];
    bit     m_locked;
    int     rl1;   // high run-length of raw lock, sample n-1
    int     rl2;   // high run-length of raw lock, sample n-2

    clken_synth #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .cfg_upd    (cfg_upd),
        .cfg_inc    (cfg_inc),
        .cfg_busy   (cfg_busy),
        .ce         (ce),
        .ce_n       (ce_n),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_phase[c] = 0; m_rate[c] = 0; m_pend[c] = 0;
            m_busy[c] = 1'b0; m_ce[c] = 1'b0; m_cen[c] = 1'b0;
        end
        m_locked = 1'b0;
        rl1 = 0;
        rl2 = 0;
    endtask

    // One clock edge of the reference model, using the inputs held before the edge.
    task automatic model_edge();
        bit     run;
        bit     wrap;
        bit     apply;
        longint total;
        longint v;
        // Enables run once the raw lock has been high LOCK+2 samples, two samples ago.
        run      = (rl2 >= LOCK_CYCLES + 2);
        m_locked = (rl2 >= LOCK_CYCLES + 1);
        rl2      = rl1;
        rl1      = (pll_locked === 1'b1) ? rl1 + 1 : 0;
        for (int c = 0; c < NUM_CH; c++) begin
            total = m_phase[c] + m_rate[c];
            wrap  = run && (total >= MOD);
            apply = m_busy[c] && (!run || wrap || (m_rate[c] == 0));
            if (run) begin
                m_ce[c]    = wrap;
                m_cen[c]   = (m_phase[c] < HALF) && ((total % MOD) >= HALF);
                m_phase[c] = total % MOD;
            end else begin
                m_ce[c]    = 1'b0;
                m_cen[c]   = 1'b0;
                m_phase[c] = 0;
            end
            if (apply) m_rate[c] = m_pend[c];
            if (cfg_upd[c]) begin
                v         = longint'(cfg_inc[c*ACC_W +: ACC_W]);
                m_pend[c] = (v > HALF) ? HALF : v;
                m_busy[c] = 1'b1;
            end else if (apply) begin
                m_busy[c] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] eb;
        logic [NUM_CH-1:0] ec;
        logic [NUM_CH-1:0] en;
        for (int c = 0; c < NUM_CH; c++) begin
            eb[c] = m_busy[c];
            ec[c] = m_ce[c];
`ifdef CLKEN_SYNTH_CEN_EN
            en[c] = m_cen[c];
`else
            en[c] = 1'b0;
`endif
        end
        chk("outs{locked,busy,ce,ce_n}", {locked, cfg_busy, ce, ce_n}, {m_locked, eb, ec, en});
    endtask

    task automatic step();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        compare_all();
        cfg_upd = '0;
    endtask

    task automatic set_inc(input int c, input logic [ACC_W-1:0] v);
        cfg_upd[c] = 1'b1;
        cfg_inc[c*ACC_W +: ACC_W] = v;
    endtask

    function automatic logic [ACC_W-1:0] pick_inc();
        case ($urandom_range(0, 7))
            0:       return 24'h000000;
            1:       return 24'h400000;
            2:       return 24'h200000;
            3:       return 24'h555555;
            4:       return 24'hFFFFFF;
            5:       return 24'h800000;
            6:       return 24'h800001;
            default: return ACC_W'($urandom_range(0, 32'hFFFFFF));
        endcase
    endfunction

    initial begin
        int lock_at;
        int ce_first;
        int cen_first;
        int n;
        int cnt;
        int drop_left;

        rst        = 1'b1;
        pll_locked = 1'b0;
        cfg_upd    = '0;
        cfg_inc    = '0;
        model_reset();
        repeat (2) @(negedge refclk);
        chk("reset", {locked, cfg_busy, ce, ce_n}, 64'd0);
        rst = 1'b0;

        chk("pkg_inc_for_hz", inc_for_hz(64'd1, 64'd4, 32'd24), 64'h400000);
        chk("pkg_clamp", clamp_inc(64'hFFFFFF, 32'd24), 64'h800000);

        // program all channels while unlocked: applied immediately
        set_inc(0, 24'h400000);
        set_inc(1, 24'h200000);
        set_inc(2, 24'hFFFFFF);
        step();
        step();

        // lock latency and first rate pulses
        pll_locked = 1'b1;
        lock_at = -1; ce_first = -1; cen_first = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (locked === 1'b1 && lock_at < 0) lock_at = i;
            if (ce[0] === 1'b1 && ce_first < 0) ce_first = i;
            if (ce_n[0] === 1'b1 && cen_first < 0) cen_first = i;
        end
        chk("lock_latency", lock_at, 18);
        chk("rate_first_ce", ce_first, 22);
`ifdef CLKEN_SYNTH_CEN_EN
        chk("rate_first_ce_n", cen_first, 20);
`else
        chk("ce_n_disabled", cen_first, -1);
`endif

        // mid-period update 0x400000 -> 0x200000
        n = 0;
        while (m_phase[0] != 64'h400000 && n < 8) begin step(); n++; end
        set_inc(0, 24'h200000);
        step();
        chk("upd_busy_set", cfg_busy[0], 1'b1);
        n = 0;
        while (ce[0] !== 1'b1 && n < 8) begin
            chk("upd_busy_hold", cfg_busy[0], 1'b1);
            step(); n++;
        end
        chk("upd_busy_clear", {ce[0], cfg_busy[0]}, 2'b10);
        n = 0;
        do begin step(); n++; end while (ce[0] !== 1'b1 && n < 20);
        chk("upd_spacing", n, 8);

        // collision: A then B before the wrap; B wins
        n = 0;
        while (m_phase[0] != 64'h200000 && n < 10) begin step(); n++; end
        set_inc(0, 24'h300000);
        step();
        set_inc(0, 24'h100000);
        step();
        n = 0;
        while (ce[0] !== 1'b1 && n < 10) begin step(); n++; end
        chk("coll_b_applied_busy", cfg_busy[0], 1'b0);
        n = 0;
        do begin step(); n++; end while (ce[0] !== 1'b1 && n < 40);
        chk("coll_b_spacing", n, 16);
        // write C on the wrap edge
        n = 0;
        while (m_phase[0] + m_rate[0] < MOD && n < 20) begin step(); n++; end
        set_inc(0, 24'h400000);
        step();
        chk("coll_wrap_ce", ce[0], 1'b1);
        chk("coll_wrap_busy", cfg_busy[0], 1'b1);

        // fractional rate
        set_inc(1, 24'h555555);
        step();
        n = 0;
        while (cfg_busy[1] === 1'b1 && n < 30) begin step(); n++; end
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (ce[1] === 1'b1) cnt++;
        end
        chk("frac_count_1000pm1", (cnt >= 999 && cnt <= 1001), 1'b1);

        // stop: inc 0 produces no enables
        set_inc(2, 24'h000000);
        repeat (6) step();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ce[2] === 1'b1 || ce_n[2] === 1'b1) cnt++;
        end
        chk("stop_no_ce", cnt, 0);

        // single-cycle lock drop
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        chk("drop_locked", locked, 1'b0);
        chk("drop_ce", {ce, ce_n}, 64'd0);

        // randomised writes and lock drops
        drop_left = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) set_inc(c, pick_inc());
            end
            if (drop_left > 0) begin
                pll_locked = 1'b0;
                drop_left--;
            end else begin
                pll_locked = 1'b1;
                if ($urandom_range(0, 399) == 0) drop_left = $urandom_range(1, 3);
            end
            step();
        end

        // asynchronous reset mid-run
        pll_locked = 1'b1;
        set_inc(0, 24'h800000);
        repeat (40) step();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {locked, cfg_busy, ce, ce_n}, 64'd0);
        model_reset();
        @(negedge refclk);
        rst = 1'b0;
        set_inc(0, 24'h400000);
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
